// File: rtl/cnt_sched_pkg.sv
// Shared state encoding, digit width and terminal-count helper for the counter-chain scheduler.
// No logic; imported by cnt_nibble and cnt_chain_sched.
package cnt_sched_pkg;

   localparam int NIB_W = 4;

   typedef enum logic [1:0] {
      CS_IDLE = 2'd0,
      CS_LOAD = 2'd1,
      CS_RUN  = 2'd2,
      CS_DONE = 2'd3
   } cnt_state_t;

   // All-ones terminal value for a chain of width w (w <= 64).
   function automatic logic [63:0] term_count(input int w);
      logic [63:0] r;
      r = '0;
      for (int i = 0; i < 64; i++) begin
         if (i < w) r[i] = 1'b1;
      end
      return r;
   endfunction

endpackage

// File: rtl/cnt_nibble.sv
// One 4-bit loadable up-counter digit: LD has priority over CE, CO = &Q & CE.
// Latency: one CLK edge per load/increment; no backpressure, CO is combinational.
module cnt_nibble
   import cnt_sched_pkg::*;
(
   input  logic             CLK,
   input  logic             CLR,
   input  logic             LD,
   input  logic             CE,
   input  logic [NIB_W-1:0] D,
   output logic [NIB_W-1:0] Q,
   output logic             CO
);

   logic [NIB_W-1:0] q_q;
   logic [NIB_W-1:0] q_d;

   always_comb begin
      q_d = q_q;
      if (LD) begin
         q_d = D;
      end else if (CE) begin
         q_d = q_q + NIB_W'(1);
      end
   end

   always_ff @(posedge CLK or posedge CLR) begin
      if (CLR) begin
         q_q <= '0;
      end else begin
         q_q <= q_d;
      end
   end

   assign Q  = q_q;
   assign CO = (&q_q) & CE;

endmodule

// File: rtl/cnt_chain_sched.sv
// Sequencer for a cascade of 4-bit digits: latches a preset, loads, counts, detects all-ones and stops or reloads.
// Latency: LOAD is one cycle, TICK registered one cycle after the terminal edge; no backpressure. Optional HOLD via CNT_CHAIN_SCHED_HOLD_EN.
module cnt_chain_sched
   import cnt_sched_pkg::*;
#(
   parameter int DIGITS = 4
)(
   input  logic                      CLK,
   input  logic                      CLR,
   input  logic                      START,
   input  logic                      STOP,
   input  logic                      MODE,
   input  logic [NIB_W*DIGITS-1:0]   PRESET,
`ifdef CNT_CHAIN_SCHED_HOLD_EN
   input  logic                      HOLD,
`endif
   output logic [NIB_W*DIGITS-1:0]   Q,
   output logic                      CO,
   output logic                      TICK,
   output logic                      BUSY,
   output logic                      DONE
);

   localparam int W = NIB_W * DIGITS;

   cnt_state_t     state_q, state_d;
   logic [W-1:0]   preset_q, preset_d;
   logic           mode_q, mode_d;
   logic           tick_q, tick_d;

   logic           hold_w;
   logic           chain_en;
   logic           req_start;
   logic           quiet;
   logic           at_term;
   logic           term_evt;
   logic           count_ok;
   logic           load_preset;
   logic           freeze;
   logic           ld_w;
   logic [W-1:0]   q_w;
   logic [W-1:0]   d_w;
   logic [DIGITS-1:0] ce_w;
   logic [DIGITS-1:0] co_w;

`ifdef CNT_CHAIN_SCHED_HOLD_EN
   assign hold_w = HOLD;
`else
   assign hold_w = 1'b0;
`endif

   assign chain_en  = (state_q == CS_RUN) & ~hold_w;
   assign req_start = START & ~STOP;
   assign quiet     = ~START & ~STOP;
   assign at_term   = co_w[DIGITS-1];
   assign term_evt  = at_term & quiet;

   // A one-shot terminal or a pending STOP/START must not let the chain wrap.
   assign count_ok    = quiet & ~(at_term & ~mode_q);
   assign load_preset = quiet & ((state_q == CS_LOAD) | (term_evt & mode_q));
   assign freeze      = chain_en & ~count_ok;

   // Freezing reuses the digit load path with each digit's own value.
   assign ld_w = load_preset | freeze;
   assign d_w  = load_preset ? preset_q : q_w;

   for (genvar g = 0; g < DIGITS; g++) begin : g_dig
      if (g == 0) begin : g_first
         assign ce_w[g] = chain_en;
      end else begin : g_rest
         assign ce_w[g] = co_w[g-1];
      end

      cnt_nibble u_dig (
         .CLK (CLK),
         .CLR (CLR),
         .LD  (ld_w),
         .CE  (ce_w[g]),
         .D   (d_w[g*NIB_W +: NIB_W]),
         .Q   (q_w[g*NIB_W +: NIB_W]),
         .CO  (co_w[g])
      );
   end

   always_ff @(posedge CLK or posedge CLR) begin
      if (CLR) begin
         state_q  <= CS_IDLE;
         preset_q <= '0;
         mode_q   <= 1'b0;
         tick_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         preset_q <= preset_d;
         mode_q   <= mode_d;
         tick_q   <= tick_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      preset_d = preset_q;
      mode_d   = mode_q;
      tick_d   = term_evt;
      if (req_start) begin
         preset_d = PRESET;
         mode_d   = MODE;
      end
      unique case (state_q)
         CS_IDLE: begin
            if (req_start) state_d = CS_LOAD;
         end
         CS_LOAD: begin
            if (STOP)       state_d = CS_IDLE;
            else if (START) state_d = CS_LOAD;
            else            state_d = CS_RUN;
         end
         CS_RUN: begin
            if (STOP)                      state_d = CS_IDLE;
            else if (START)                state_d = CS_LOAD;
            else if (term_evt && !mode_q)  state_d = CS_DONE;
         end
         CS_DONE: begin
            if (STOP)       state_d = CS_IDLE;
            else if (START) state_d = CS_LOAD;
         end
         default: state_d = CS_IDLE;
      endcase
   end

   always_comb begin
      BUSY = (state_q == CS_LOAD) || (state_q == CS_RUN);
      DONE = (state_q == CS_DONE);
      TICK = tick_q;
      Q    = q_w;
      CO   = at_term;
   end

endmodule

// File: tb/tb_cnt_chain_sched.sv
// Randomized plus directed bench for cnt_chain_sched (DIGITS=2) against a cycle-level behavioural model.
module tb_cnt_chain_sched;

   localparam int DIGITS = 2;
   localparam int W      = 4 * DIGITS;
   localparam int MAXV   = (1 << W) - 1;
   localparam int S_IDLE = 0, S_LOAD = 1, S_RUN = 2, S_DONE = 3;

   logic         CLK   = 1'b0;
   logic         CLR   = 1'b1;
   logic         START = 1'b0;
   logic         STOP  = 1'b0;
   logic         MODE  = 1'b0;
   logic [W-1:0] PRESET = '0;
   logic [W-1:0] Q;
   logic         CO, TICK, BUSY, DONE;
   logic         hold_v;

`ifdef CNT_CHAIN_SCHED_HOLD_EN
   logic         HOLD = 1'b0;
   assign hold_v = HOLD;
`else
   assign hold_v = 1'b0;
`endif

   int n_vec = 0;
   int n_err = 0;

   int m_st = S_IDLE;
   int m_q = 0, m_pre = 0, m_mode = 0, m_tick = 0;

   cnt_chain_sched #(.DIGITS(DIGITS)) dut (
      .CLK    (CLK),
      .CLR    (CLR),
      .START  (START),
      .STOP   (STOP),
      .MODE   (MODE),
      .PRESET (PRESET),
`ifdef CNT_CHAIN_SCHED_HOLD_EN
      .HOLD   (HOLD),
`endif
      .Q      (Q),
      .CO     (CO),
      .TICK   (TICK),
      .BUSY   (BUSY),
      .DONE   (DONE)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: actual=%h required=%h", nm, $time, act, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   // Reference: one transaction-level update per edge, straight from the timer rules.
   always @(posedge CLK or posedge CLR) begin
      if (CLR) begin
         m_st <= S_IDLE; m_q <= 0; m_pre <= 0; m_mode <= 0; m_tick <= 0;
      end else begin
         m_tick <= 0;
         if (STOP) begin
            m_st <= S_IDLE;
         end else if (START) begin
            m_pre  <= int'(PRESET);
            m_mode <= int'(MODE);
            m_st   <= S_LOAD;
         end else if (m_st == S_LOAD) begin
            m_q  <= m_pre;
            m_st <= S_RUN;
         end else if (m_st == S_RUN && !hold_v) begin
            if (m_q == MAXV) begin
               m_tick <= 1;
               if (m_mode != 0) m_q <= m_pre;
               else             m_st <= S_DONE;
            end else begin
               m_q <= (m_q + 1) % (MAXV + 1);
            end
         end
      end
   end

   always @(negedge CLK) begin
      if (!CLR) begin
         chk("q",    32'(Q),    32'(m_q));
         chk("tick", 32'(TICK), 32'(m_tick));
         chk("busy", 32'(BUSY), 32'((m_st == S_LOAD) || (m_st == S_RUN)));
         chk("done", 32'(DONE), 32'(m_st == S_DONE));
         chk("co",   32'(CO),   32'((m_q == MAXV) && (m_st == S_RUN) && !hold_v));
      end
   end

   initial begin
      step();
      chk("rst_q",    32'(Q),    32'h0);
      chk("rst_busy", 32'(BUSY), 32'h0);
      chk("rst_done", 32'(DONE), 32'h0);
      chk("rst_co",   32'(CO),   32'h0);
      step();
      CLR = 1'b0;

      // One-shot FD: LOAD, FD, FE, FF, then DONE with TICK.
      PRESET = 8'hFD; MODE = 1'b0; START = 1'b1;
      step(); START = 1'b0; PRESET = 8'h00;
      chk("os_load_busy", 32'(BUSY), 32'h1);
      step(); chk("os_q_fd", 32'(Q), 32'hFD);
      step(); chk("os_q_fe", 32'(Q), 32'hFE);
      step(); chk("os_q_ff", 32'(Q), 32'hFF); chk("os_co_ff", 32'(CO), 32'h1);
      chk("os_tick_pre", 32'(TICK), 32'h0);
      step(); chk("os_done", 32'(DONE), 32'h1); chk("os_tick", 32'(TICK), 32'h1);
      chk("os_q_hold", 32'(Q), 32'hFF); chk("os_co_done", 32'(CO), 32'h0);
      step(); chk("os_tick_end", 32'(TICK), 32'h0); chk("os_done2", 32'(DONE), 32'h1);
      STOP = 1'b1; step(); STOP = 1'b0;
      chk("stop_done_idle", 32'(DONE), 32'h0); chk("stop_q", 32'(Q), 32'hFF);

      // Auto-reload FA: period 6, ten periods.
      PRESET = 8'hFA; MODE = 1'b1; START = 1'b1;
      step(); START = 1'b0; MODE = 1'b0;
      for (int k = 0; k <= 60; k++) begin
         step();
         chk("ar_q",    32'(Q),    32'(8'hFA + (k % 6)));
         chk("ar_tick", 32'(TICK), 32'((k > 0) && (k % 6 == 0)));
      end

      // STOP and START together in RUN: STOP wins, Q holds.
      PRESET = 8'h11; STOP = 1'b1; START = 1'b1;
      step(); STOP = 1'b0; START = 1'b0;
      chk("coll_busy", 32'(BUSY), 32'h0); chk("coll_q", 32'(Q), 32'hFA);

      // Digit carry: 0E, 0F, 10.
      PRESET = 8'h0E; MODE = 1'b0; START = 1'b1;
      step(); START = 1'b0;
      step(); chk("cas_0e", 32'(Q), 32'h0E); chk("cas_co0", 32'(CO), 32'h0);
      step(); chk("cas_0f", 32'(Q), 32'h0F); chk("cas_co1", 32'(CO), 32'h0);
      step(); chk("cas_10", 32'(Q), 32'h10); chk("cas_co2", 32'(CO), 32'h0);

      // START on the terminal edge: reload new preset, no TICK.
      PRESET = 8'hFE; MODE = 1'b1; START = 1'b1;
      step(); START = 1'b0;
      step(); step(); chk("rs_ff", 32'(Q), 32'hFF);
      PRESET = 8'h40; MODE = 1'b0; START = 1'b1;
      step(); START = 1'b0;
      chk("rs_tick", 32'(TICK), 32'h0); chk("rs_busy", 32'(BUSY), 32'h1);
      step(); chk("rs_q40", 32'(Q), 32'h40); chk("rs_tick2", 32'(TICK), 32'h0);

`ifdef CNT_CHAIN_SCHED_HOLD_EN
      PRESET = 8'hFD; MODE = 1'b0; START = 1'b1;
      step(); START = 1'b0;
      step(); step(); step(); chk("hold_ff", 32'(Q), 32'hFF);
      HOLD = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step(); chk("hold_q", 32'(Q), 32'hFF); chk("hold_tick", 32'(TICK), 32'h0);
      end
      HOLD = 1'b0;
      step(); chk("hold_tick_after", 32'(TICK), 32'h1); chk("hold_done", 32'(DONE), 32'h1);
`endif

      // Asynchronous clear mid-run at Q=37.
      PRESET = 8'h30; MODE = 1'b0; START = 1'b1;
      step(); START = 1'b0;
      repeat (8) step();
      chk("clr_pre_q", 32'(Q), 32'h37);
      CLR = 1'b1; #1;
      chk("clr_q",    32'(Q),    32'h0);
      chk("clr_busy", 32'(BUSY), 32'h0);
      chk("clr_done", 32'(DONE), 32'h0);
      chk("clr_tick", 32'(TICK), 32'h0);
      step(); step();
      CLR = 1'b0;

      repeat (3000) begin
         START  = ($urandom % 24) == 0;
         STOP   = ($urandom % 60) == 0;
         MODE   = $urandom % 2;
         PRESET = ($urandom % 2) ? (8'hF0 | W'($urandom % 16)) : W'($urandom);
`ifdef CNT_CHAIN_SCHED_HOLD_EN
         HOLD   = ($urandom % 8) == 0;
`endif
         step();
      end
      START = 1'b0; STOP = 1'b0;
      step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
